// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU definitions used by the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef logic              Bit_t;
    typedef logic [DATA_W-1:0] Word_t;
    typedef logic [ADDR_W-1:0] Addr_t;
    typedef logic [BE_W-1:0]   ByteEn_t;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM,
        RESP,
        DRAIN
    } ArbState_t;

    typedef struct packed {
        Bit_t    we;
        ByteEn_t be;
        Addr_t   addr;
        Word_t   wdata;
    } BusCmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External memory bus: the arbiter is master, the memory controller is slave.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned DATA_WIDTH = DATA_W
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  bus_req;
    logic                  bus_we;
    logic [BE_WIDTH-1:0]   bus_be;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_ack;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch and data
// access, one multi-cycle bus transaction at a time, MEM before IF.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned DATA_WIDTH = DATA_W
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_done_o,
    output logic                    stall_from_if_o,
    input  logic                    mem_req_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH/8-1:0] mem_be_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_done_o,
    output logic                    stall_from_mem_o,
    mem_port_arbiter_if.master      bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    ArbState_t state_q;
    BusCmd_t   cmd_q;
    logic      bus_req_q;
    logic      if_done_q;
    logic      mem_done_q;
    Word_t     if_rdata_q;
    Word_t     mem_rdata_q;

    // Transaction FSM with the bus command register and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            bus_req_q   <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A flush cancels whatever is being requested this cycle.
                    if (!flush_i) begin
                        if (mem_req_i) begin
                            cmd_q <= '{we:    mem_we_i,
                                       be:    BE_W'(mem_be_i),
                                       addr:  ADDR_W'(mem_addr_i),
                                       wdata: DATA_W'(mem_wdata_i)};
                            bus_req_q <= 1'b1;
                            state_q   <= BUSY_MEM;
                        end else if (if_req_i) begin
                            cmd_q <= '{we:    1'b0,
                                       be:    '1,
                                       addr:  ADDR_W'(if_addr_i),
                                       wdata: '0};
                            bus_req_q <= 1'b1;
                            state_q   <= BUSY_IF;
                        end
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    if (bus.bus_ack) begin
                        bus_req_q <= 1'b0;
                        if (flush_i) begin
                            state_q <= IDLE;
                        end else begin
                            if (state_q == BUSY_MEM) begin
                                mem_rdata_q <= DATA_W'(bus.bus_rdata);
                                mem_done_q  <= 1'b1;
                            end else begin
                                if_rdata_q <= DATA_W'(bus.bus_rdata);
                                if_done_q  <= 1'b1;
                            end
                            state_q <= RESP;
                        end
                    end else if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                RESP: begin
                    // Held requests belong to the access just completed.
                    state_q <= IDLE;
                end
                DRAIN: begin
                    if (bus.bus_ack) begin
                        bus_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    bus_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Bus command straight from the command register.
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = cmd_q.we;
    assign bus.bus_be    = BE_WIDTH'(cmd_q.be);
    assign bus.bus_addr  = ADDR_WIDTH'(cmd_q.addr);
    assign bus.bus_wdata = DATA_WIDTH'(cmd_q.wdata);

    // Done pulses are withdrawn by a flush arriving in the RESP cycle.
    assign if_done_o  = if_done_q & ~flush_i;
    assign mem_done_o = mem_done_q & ~flush_i;

    assign if_rdata_o  = DATA_WIDTH'(if_rdata_q);
    assign mem_rdata_o = DATA_WIDTH'(mem_rdata_q);

    // Stall while a request is outstanding, including through a drain.
    assign stall_from_if_o  = if_req_i & ~if_done_o;
    assign stall_from_mem_o = mem_req_i & ~mem_done_o;

endmodule
